// File: rtl/seq_recursive_mul8_ctrl_if.sv
// rtl/seq_recursive_mul8_ctrl_if.sv - operand/product handshake bundle for seq_recursive_mul8_ctrl
//
// Purpose: groups the operand-side and product-side valid/ready handshakes
// together with the status outputs of the sequential 8x8 multiplier.
// Signals:
//   in_valid  / in_ready   operand pair handshake (a, b unsigned 8-bit)
//   out_valid / out_ready  product handshake (y unsigned 16-bit)
//   busy                   operation in progress
//   op_count               completed product handoffs, CNT_W bits, wrapping
// Modports: master drives operands and out_ready, slave is the multiplier.
interface seq_recursive_mul8_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       a;
    logic [7:0]       b;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      y;
    logic             busy;
    logic [CNT_W-1:0] op_count;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, y, busy, op_count
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, y, busy, op_count
    );
endinterface

// File: rtl/seq_recursive_mul8_ctrl.sv
// rtl/seq_recursive_mul8_ctrl.sv - sequential 8x8 recursive multiplier using one shared 4x4 unit
//
// Purpose: computes y = a * b (unsigned 8x8 -> 16) by visiting the four
// quadrant products aL*bL, aH*bL, aL*bH, aH*bH on a single 4x4 multiplier
// and accumulating the shifted partial products into a 16-bit register.
// Optional feature macro: APPROX_LL_EN - when defined, the aL*bL quadrant uses
// an OR-compressed approximate 4x4 product; the other quadrants stay exact.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset, aborts any operation in flight
//   bus   seq_recursive_mul8_ctrl_if.slave (handshakes, y, busy, op_count)
module seq_recursive_mul8_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    seq_recursive_mul8_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LL,
        S_HL,
        S_LH,
        S_HH,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [7:0]       a_q;
    logic [7:0]       b_q;
    logic [15:0]      acc_q;
    logic [15:0]      acc_d;
    logic [CNT_W-1:0] op_count_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;

    logic [3:0]       mul_x;
    logic [3:0]       mul_w;
    logic [7:0]       exact_p;
    logic [7:0]       ll_p;
    logic [15:0]      term;

`ifdef APPROX_LL_EN
    // OR-compressed 4x4: each output column ORs its partial products instead
    // of summing them; the top two bits split pp33 on pp22.
    function automatic logic [7:0] approx_mul4(input logic [3:0] x, input logic [3:0] w);
        logic [7:0] r;
        r[0] = x[0] & w[0];
        r[1] = (x[1] & w[0]) | (x[0] & w[1]);
        r[2] = (x[2] & w[0]) | (x[1] & w[1]) | (x[0] & w[2]);
        r[3] = (x[3] & w[0]) | (x[2] & w[1]) | (x[1] & w[2]) | (x[0] & w[3]);
        r[4] = (x[3] & w[1]) | (x[2] & w[2]) | (x[1] & w[3]);
        r[5] = (x[3] & w[2]) | (x[2] & w[3]);
        r[6] = (x[3] & w[3]) & ~(x[2] & w[2]);
        r[7] = (x[3] & w[3]) & (x[2] & w[2]);
        return r;
    endfunction
`endif

    // Operand muxes for the shared 4x4 unit, selected by the quadrant state.
    always_comb begin
        mul_x = a_q[3:0];
        mul_w = b_q[3:0];
        case (state_q)
            S_HL: begin
                mul_x = a_q[7:4];
                mul_w = b_q[3:0];
            end
            S_LH: begin
                mul_x = a_q[3:0];
                mul_w = b_q[7:4];
            end
            S_HH: begin
                mul_x = a_q[7:4];
                mul_w = b_q[7:4];
            end
            default: begin
                mul_x = a_q[3:0];
                mul_w = b_q[3:0];
            end
        endcase
    end

    assign exact_p = {4'b0000, mul_x} * {4'b0000, mul_w};

`ifdef APPROX_LL_EN
    assign ll_p = approx_mul4(mul_x, mul_w);
`else
    assign ll_p = exact_p;
`endif

    // Align the current quadrant product to its weight in the result.
    always_comb begin
        term = 16'h0000;
        case (state_q)
            S_LL:       term = {8'h00, ll_p};
            S_HL, S_LH: term = {4'h0, exact_p, 4'h0};
            S_HH:       term = {exact_p, 8'h00};
            default:    term = 16'h0000;
        endcase
    end

    // The largest possible sum stays below 2^16, so the carry-out is dropped.
    assign acc_d = acc_q + term;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= 8'h00;
            b_q         <= 8'h00;
            acc_q       <= 16'h0000;
            op_count_q  <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        a_q        <= bus.a;
                        b_q        <= bus.b;
                        acc_q      <= 16'h0000;
                        state_q    <= S_LL;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                S_LL: begin
                    acc_q   <= acc_d;
                    state_q <= S_HL;
                end
                S_HL: begin
                    acc_q   <= acc_d;
                    state_q <= S_LH;
                end
                S_LH: begin
                    acc_q   <= acc_d;
                    state_q <= S_HH;
                end
                S_HH: begin
                    acc_q       <= acc_d;
                    state_q     <= S_DONE;
                    out_valid_q <= 1'b1;
                end
                S_DONE: begin
                    // acc is left untouched here, so y holds under back-pressure.
                    if (bus.out_ready) begin
                        op_count_q  <= op_count_q + CNT_W'(1);
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.y         = acc_q;
    assign bus.busy      = busy_q;
    assign bus.op_count  = op_count_q;

endmodule

// File: tb/tb_seq_recursive_mul8_ctrl.sv
// tb/tb_seq_recursive_mul8_ctrl.sv - directed self-checking bench for seq_recursive_mul8_ctrl
module tb_seq_recursive_mul8_ctrl;

    localparam int CNT_W = 16;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [CNT_W-1:0] exp_count;

    seq_recursive_mul8_ctrl_if #(.CNT_W(CNT_W)) bus ();

    seq_recursive_mul8_ctrl #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present operands in IDLE and wait (bounded) for out_valid.
    // edges counts rising edges from the accept edge (inclusive).
    task automatic start_and_wait(input logic [7:0] av, input logic [7:0] bv, output int edges);
        bus.a        = av;
        bus.b        = bv;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        edges = 1;
        while (!bus.out_valid && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = 8'h00;
        bus.b         = 8'h00;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got %b want 0", bus.out_valid);
        end
        checks++;
        if (bus.y !== 16'h0000) begin
            errors++;
            $display("FAIL reset_y got %h want 0000", bus.y);
        end
        checks++;
        if (bus.op_count !== '0) begin
            errors++;
            $display("FAIL reset_op_count got %0d want 0", bus.op_count);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got %b want 0", bus.busy);
        end
        exp_count = '0;
    endtask

    task automatic test_product(input string name, input logic [7:0] av, input logic [7:0] bv,
                                input logic [15:0] exp_y);
        int edges;
        bus.out_ready = 1'b1;
        start_and_wait(av, bv, edges);
        checks++;
        if (edges !== 5) begin
            errors++;
            $display("FAIL %s_latency got %0d edges want 5", name, edges);
        end
        checks++;
        if (bus.y !== exp_y) begin
            errors++;
            $display("FAIL %s_y got %h want %h", name, bus.y, exp_y);
        end
        checks++;
        if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_done_flags got in_ready=%b busy=%b want 0 1", name, bus.in_ready, bus.busy);
        end
        @(posedge clk);
        #1;
        exp_count = exp_count + 1'b1;
        checks++;
        if (bus.op_count !== exp_count) begin
            errors++;
            $display("FAIL %s_op_count got %0d want %0d", name, bus.op_count, exp_count);
        end
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle got out_valid=%b in_ready=%b busy=%b want 0 1 0",
                     name, bus.out_valid, bus.in_ready, bus.busy);
        end
    endtask

    task automatic test_backpressure();
        int edges;
        // 0xA5 * 0x3C = 165 * 60 = 9900; the LL quadrant 5*12 is exact in both configs
        bus.out_ready = 1'b0;
        start_and_wait(8'hA5, 8'h3C, edges);
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_reach_done got out_valid=%b want 1", bus.out_valid);
        end
        bus.in_valid = 1'b1;
        bus.a        = 8'hFF;
        bus.b        = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.y !== 16'h26AC || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle %0d got y=%h out_valid=%b in_ready=%b want 26ac 1 0",
                         i, bus.y, bus.out_valid, bus.in_ready);
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        exp_count = exp_count + 1'b1;
        checks++;
        if (bus.op_count !== exp_count) begin
            errors++;
            $display("FAIL bp_op_count got %0d want %0d", bus.op_count, exp_count);
        end
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.y !== 16'h26AC) begin
            errors++;
            $display("FAIL bp_idle got in_ready=%b out_valid=%b y=%h want 1 0 26ac",
                     bus.in_ready, bus.out_valid, bus.y);
        end
    endtask

    task automatic test_reset_midop();
        bus.out_ready = 1'b1;
        bus.a         = 8'hFF;
        bus.b         = 8'hFF;
        bus.in_valid  = 1'b1;
        @(posedge clk);     // accept -> LL
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);     // LL -> HL
        #1;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL midop_busy got %b want 1", bus.busy);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_count = '0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.y !== 16'h0000 || bus.op_count !== '0 ||
            bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL midop_reset got out_valid=%b y=%h op_count=%0d in_ready=%b busy=%b want 0 0000 0 1 0",
                     bus.out_valid, bus.y, bus.op_count, bus.in_ready, bus.busy);
        end
        // no stray product may appear after the abort
        repeat (6) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL midop_no_output got out_valid=%b want 0", bus.out_valid);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_count = '0;
        test_reset();
        test_product("p12x34", 8'h12, 8'h34, 16'h03A8);
`ifdef APPROX_LL_EN
        test_product("pFFxFF", 8'hFF, 8'hFF, 16'hFDDF);
        test_product("p0Fx0F", 8'h0F, 8'h0F, 16'h00BF);
`else
        test_product("pFFxFF", 8'hFF, 8'hFF, 16'hFE01);
        test_product("p0Fx0F", 8'h0F, 8'h0F, 16'h00E1);
`endif
        test_product("p00xFF", 8'h00, 8'hFF, 16'h0000);
        test_backpressure();
        test_reset_midop();
        test_product("p03x05", 8'h03, 8'h05, 16'h000F);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
